// File: rtl/lsu_if.sv
// Core/memory-side bundle for load_store_unit: request handshake, load result and word-memory port.
// The master side is the core plus data memory; the slave side is the LSU.
interface lsu_if #(
   parameter int N = 10
);
   logic        req;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        misaligned;
   logic        fault;
   logic        mem_we;
   logic [N-1:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport master (
      output req, we, funct3, addr, wdata, mem_rd,
      input  rdata, busy, done, misaligned, fault, mem_we, mem_a, mem_wd
   );

   modport slave (
      input  req, we, funct3, addr, wdata, mem_rd,
      output rdata, busy, done, misaligned, fault, mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a 1-cycle synchronous word memory (sub-word stores via read-modify-write).
// Define LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses instead of forcing alignment.
module load_store_unit #(
   parameter int N = 10
) (
   input  logic  clk,
   input  logic  rst_n,
   lsu_if.slave  bus
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RMW_WAIT  = 2'd2
   } state_t;

   state_t        state;
   logic [N+1:0]  addr_p1;
   logic [2:0]    funct3_p1;
   logic [15:0]   wdata_p1;
   logic          we_p1;
   logic [31:0]   rdata_q;
   logic          done_q;
   logic          misaligned_q;
   logic          fault_q;

   logic          illegal;
   logic          misal;
   logic          is_sw;
   logic          sw_go;
   logic          unused_addr_hi;

   // Little-endian lane extraction with sign or zero extension.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_BU:   r = {24'd0, b};
         F3_HU:   r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace one byte or halfword lane of the old word; halfwords only look at lane[1].
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3,
                                               input logic [15:0] d);
      logic [31:0] r;
      r = word;
      if (f3 == F3_B) begin
         case (lane)
            2'd0:    r[7:0]   = d[7:0];
            2'd1:    r[15:8]  = d[7:0];
            2'd2:    r[23:16] = d[7:0];
            default: r[31:24] = d[7:0];
         endcase
      end else if (lane[1]) begin
         r[31:16] = d;
      end else begin
         r[15:0] = d;
      end
      return r;
   endfunction

   // Request decode against the live inputs; only meaningful in IDLE with req.
   always_comb begin
      illegal = 1'b0;
      if (bus.we) begin
         illegal = !(bus.funct3 inside {F3_B, F3_H, F3_W});
      end else begin
         illegal = !(bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      end
`ifdef LSU_MISALIGN_CHECK_EN
      misal = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
              ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
      misal = 1'b0;
`endif
      is_sw = bus.we && (bus.funct3 == F3_W);
      sw_go = (state == IDLE) && bus.req && !illegal && !misal && is_sw;
   end

   // Memory port: SW writes straight through, sub-word stores write the merged word from RMW_WAIT.
   always_comb begin
      bus.mem_a  = (state == IDLE) ? bus.addr[N+1:2] : addr_p1[N+1:2];
      bus.mem_we = 1'b0;
      bus.mem_wd = bus.wdata;
      if (state == RMW_WAIT) begin
         bus.mem_we = we_p1;
         bus.mem_wd = store_merge(bus.mem_rd, addr_p1[1:0], funct3_p1, wdata_p1);
      end else if (sw_go) begin
         bus.mem_we = 1'b1;
      end
      if (!rst_n) begin
         bus.mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         addr_p1      <= '0;
         funct3_p1    <= '0;
         wdata_p1     <= '0;
         we_p1        <= 1'b0;
         rdata_q      <= '0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         fault_q      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  addr_p1   <= bus.addr[N+1:0];
                  funct3_p1 <= bus.funct3;
                  wdata_p1  <= bus.wdata[15:0];
                  we_p1     <= bus.we;
                  if (illegal) begin
                     fault_q <= 1'b1;
                     done_q  <= 1'b1;
                  end else if (misal) begin
                     misaligned_q <= 1'b1;
                     done_q       <= 1'b1;
                  end else if (is_sw) begin
                     done_q <= 1'b1;
                  end else if (!bus.we) begin
                     state <= LOAD_WAIT;
                  end else begin
                     state <= RMW_WAIT;
                  end
               end
            end
            // Memory read data for the latched address is valid in this cycle.
            LOAD_WAIT: begin
               rdata_q <= load_extend(bus.mem_rd, addr_p1[1:0], funct3_p1);
               done_q  <= 1'b1;
               state   <= IDLE;
            end
            RMW_WAIT: begin
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rdata      = rdata_q;
   assign bus.done       = done_q;
   assign bus.misaligned = misaligned_q;
   assign bus.fault      = fault_q;
   assign bus.busy       = (state != IDLE);

   // Address bits above the memory size wrap by design.
   assign unused_addr_hi = ^bus.addr[31:N+2];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural 1-cycle word memory.
// Expectations follow LSU_MISALIGN_CHECK_EN when it is defined for the build.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_CHECK_EN
   localparam bit MC = 1'b1;
`else
   localparam bit MC = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   lsu_if #(.N(10)) bus ();

   load_store_unit #(.N(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous word memory, read-before-write.
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_a] <= bus.mem_wd;
      bus.mem_rd <= mem[bus.mem_a];
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      logic        mis;
      logic        flt;
      int          wec;
      logic [31:0] word;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] r, input int l,
                               input logic m, input logic ft, input int wc, input logic [31:0] wd);
      vec_t v;
      v.we = w; v.f3 = f; v.addr = a; v.wdata = d; v.rdata = r;
      v.lat = l; v.mis = m; v.flt = ft; v.wec = wc; v.word = wd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one access from posedge+#1; returns edges to done (-1 on timeout) and mem_we/busy cycle counts.
   task automatic do_access(input logic w, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] d, output int lat, output int wecyc, output int bsy);
      lat = -1; wecyc = 0; bsy = 0;
      bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d; bus.req = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         if (bus.mem_we) wecyc++;
         if (bus.busy) bsy++;
         @(posedge clk);
         #1;
         if (e == 1) bus.req = 1'b0;
         if (bus.done) begin
            lat = e;
            break;
         end
      end
   endtask

   vec_t vecs [19];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, wec, bsy, cnt;
      logic [31:0] w14, w16;
      n_checks = 0;
      n_fail   = 0;
      w14 = MC ? 32'hCAFE77BB : 32'hCAFEBEEF;
      w16 = MC ? 32'hCAFE77BB : 32'h11223344;

      vecs[0]  = mk(1, 3'b010, 32'h10, 32'h8899AABB, 32'h0, 1, 0, 0, 1, 32'h8899AABB);
      vecs[1]  = mk(0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 2, 0, 0, 0, 32'h8899AABB);
      vecs[2]  = mk(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 2, 0, 0, 0, 32'h8899AABB);
      vecs[3]  = mk(0, 3'b100, 32'h13, 32'h0, 32'h00000088, 2, 0, 0, 0, 32'h8899AABB);
      vecs[4]  = mk(0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 2, 0, 0, 0, 32'h8899AABB);
      vecs[5]  = mk(0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 2, 0, 0, 0, 32'h8899AABB);
      vecs[6]  = mk(1, 3'b000, 32'h11, 32'h12345677, 32'h0000AABB, 2, 0, 0, 1, 32'h889977BB);
      vecs[7]  = mk(1, 3'b001, 32'h12, 32'h0000CAFE, 32'h0000AABB, 2, 0, 0, 1, 32'hCAFE77BB);
      vecs[8]  = mk(0, 3'b010, 32'h12, 32'h0, MC ? 32'h0000AABB : 32'hCAFE77BB, MC ? 1 : 2,
                    MC, 0, 0, 32'hCAFE77BB);
      vecs[9]  = mk(0, 3'b000, 32'h11, 32'h0, 32'h00000077, 2, 0, 0, 0, 32'hCAFE77BB);
      vecs[10] = mk(0, 3'b011, 32'h10, 32'h0, 32'h00000077, 1, 0, 1, 0, 32'hCAFE77BB);
      vecs[11] = mk(1, 3'b011, 32'h10, 32'h0, 32'h00000077, 1, 0, 1, 0, 32'hCAFE77BB);
      vecs[12] = mk(0, 3'b001, 32'h11, 32'h0, MC ? 32'h00000077 : 32'h000077BB, MC ? 1 : 2,
                    MC, 0, 0, 32'hCAFE77BB);
      vecs[13] = mk(0, 3'b010, 32'hFFFFF010, 32'h0, 32'hCAFE77BB, 2, 0, 0, 0, 32'hCAFE77BB);
      vecs[14] = mk(1, 3'b001, 32'h11, 32'h0000BEEF, 32'hCAFE77BB, MC ? 1 : 2,
                    MC, 0, MC ? 0 : 1, w14);
      vecs[15] = mk(0, 3'b101, 32'h12, 32'h0, 32'h0000CAFE, 2, 0, 0, 0, w14);
      vecs[16] = mk(1, 3'b010, 32'h12, 32'h11223344, 32'h0000CAFE, 1, MC, 0, MC ? 0 : 1, w16);
      vecs[17] = mk(0, 3'b010, 32'h10, 32'h0, w16, 2, 0, 0, 0, w16);
      vecs[18] = mk(1, 3'b100, 32'h10, 32'hFFFFFFFF, w16, 1, 0, 1, 0, w16);

      // Reset state
      rst_n = 1'b0;
      bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset rdata", bus.rdata, 32'h0);
      chk("reset done", 32'(bus.done), 32'h0);
      chk("reset misaligned", 32'(bus.misaligned), 32'h0);
      chk("reset fault", 32'(bus.fault), 32'h0);
      chk("reset busy", 32'(bus.busy), 32'h0);
      chk("reset mem_we", 32'(bus.mem_we), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle address passthrough
      bus.addr = 32'h00000ABC;
      #1;
      chk("idle mem_a", 32'(bus.mem_a), 32'h2AF);
      chk("idle mem_we", 32'(bus.mem_we), 32'h0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 19; i++) begin
         do_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, wec, bsy);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d busy cycles", i), 32'(bsy), 32'(vecs[i].lat - 1));
         chk($sformatf("v%0d mem_we cycles", i), 32'(wec), 32'(vecs[i].wec));
         chk($sformatf("v%0d rdata", i), bus.rdata, vecs[i].rdata);
         chk($sformatf("v%0d misaligned", i), 32'(bus.misaligned), 32'(vecs[i].mis));
         chk($sformatf("v%0d fault", i), 32'(bus.fault), 32'(vecs[i].flt));
         chk($sformatf("v%0d mem word", i), mem[vecs[i].addr[11:2]], vecs[i].word);
      end

      // req pulsed while busy must be ignored
      bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h10; bus.req = 1'b1;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      chk("pulse busy", 32'(bus.busy), 32'h1);
      bus.we = 1'b1; bus.funct3 = 3'b010; bus.wdata = 32'hDEADBEEF; bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      cnt = 0;
      for (int e = 0; e < 6; e++) begin
         @(posedge clk);
         #1;
         if (bus.done) cnt++;
      end
      chk("pulse done count", 32'(cnt), 32'h1);
      chk("pulse rdata", bus.rdata, MC ? 32'hFFFFFFBB : 32'h00000044);
      chk("pulse mem word", mem[4], w16);

      // Back-to-back: req held through done starts the next access
      bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h20; bus.wdata = 32'h5A5A0FF0; bus.req = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b sw done", 32'(bus.done), 32'h1);
      bus.we = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b lw no done", 32'(bus.done), 32'h0);
      chk("b2b lw busy", 32'(bus.busy), 32'h1);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b lw done", 32'(bus.done), 32'h1);
      chk("b2b lw rdata", bus.rdata, 32'h5A5A0FF0);

      // Reset during RMW_WAIT aborts the pending write
      do_access(1, 3'b010, 32'h30, 32'hA5A5A5A5, lat, wec, bsy);
      chk("rst prep word", mem[12], 32'hA5A5A5A5);
      bus.we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h31; bus.wdata = 32'h000000FF; bus.req = 1'b1;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      chk("rst rmw busy", 32'(bus.busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rst mem_we", 32'(bus.mem_we), 32'h0);
      chk("rst busy", 32'(bus.busy), 32'h0);
      chk("rst done", 32'(bus.done), 32'h0);
      chk("rst rdata", bus.rdata, 32'h0);
      chk("rst misaligned", 32'(bus.misaligned), 32'h0);
      chk("rst fault", 32'(bus.fault), 32'h0);
      cnt = 0;
      for (int e = 0; e < 3; e++) begin
         @(negedge clk);
         if (bus.mem_we) cnt++;
      end
      rst_n = 1'b1;
      for (int e = 0; e < 2; e++) begin
         @(negedge clk);
         if (bus.mem_we) cnt++;
      end
      chk("rst mem_we cycles", 32'(cnt), 32'h0);
      chk("rst word unchanged", mem[12], 32'hA5A5A5A5);
      chk("rst done after", 32'(bus.done), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and the synchronous word-wide data memory (1-cycle registered read, read-before-write on the same address). Turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Loads get byte-lane extraction and sign or zero extension. Sub-word stores use a read-modify-write. The core sees a `req`/`busy`/`done` handshake.

## Interface
- `N`, default 10: word-address width; memory holds 2^N 32-bit words.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 1: access request; level-sensitive, sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `funct3` in 3: RV32I width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `addr` in 32: byte address.
- `wdata` in 32: store data; the low byte or halfword is used for SB/SH.
- `rdata` out 32: extended load result, registered.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse, registered.
- `misaligned` out 1: valid with `done`; access rejected for alignment.
- `fault` out 1: valid with `done`; illegal `funct3`, access rejected.
- `mem_we` out 1: memory write enable.
- `mem_a` out N: word address, always `addr[N+1:2]` (or latched copy).
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: memory read data, valid one cycle after `mem_a` is presented.

## Operation
- States: IDLE, LOAD_WAIT, RMW_WAIT.
- **Reset:** state IDLE; `rdata`, `done`, `misaligned`, `fault`, the latched request and `mem_we` all 0.
- **IDLE, no `req`:** `mem_we` = 0 and `mem_a` follows `addr`.
- **IDLE, `req`:** latch `addr`, `funct3`, `wdata`, `we`. Then, in priority order:
  - Illegal `funct3`: `fault` = 1 and `done` = 1 next cycle. No memory access. Stay IDLE.
  - Misaligned (halfword with `addr[0]`, word with `addr[1:0]` ≠ 0): `misaligned` = 1 and `done` = 1 next cycle. No memory access.
  - SW: `mem_we` = 1 and `mem_wd` = `wdata` in the same cycle. `done` next cycle. Stay IDLE.
  - Load: go to LOAD_WAIT.
  - SB/SH: go to RMW_WAIT. `mem_we` stays 0.
- **LOAD_WAIT:**
  - Extract from `mem_rd` little-endian. Byte lane = latched `addr[1:0]`; half lane = `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - At the edge: `rdata` updated, `done` = 1, go to IDLE.
- **RMW_WAIT:**
  - `mem_wd` = `mem_rd` with the selected lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - `mem_we` = 1 for exactly this cycle. `done` next cycle. Go to IDLE.
- `rdata` changes only on a successful load; it holds its value otherwise.
- `misaligned`/`fault` are cleared whenever `done` is generated without them, and are 0 whenever `done` is 0.
- Address bits above `N+1` are ignored (address wraps modulo 2^(N+2) bytes).
- `req` while `busy` is ignored. There is no queueing; the core must hold `req` until `done`.
- `req` held high in the cycle `done` is high is accepted as a new access (back-to-back).
- `rst_n` asserted mid-access aborts immediately:
  - `mem_we` is forced to 0 while reset is asserted, so a pending RMW write never occurs.
  - Memory contents are unchanged.

## Timing
- Counting from the edge that samples `req` in IDLE:
  - SW, misaligned and fault: `done` after 1 edge.
  - Loads: `done` and `rdata` after 2 edges.
  - SB/SH: `done` after 2 edges, with the write committed on the second edge.
- `busy` is high for 1 cycle on loads and SB/SH, and 0 for SW, misaligned and fault.
- `mem_a`, `mem_we` and `mem_wd` are combinational from state, the latched request and the current inputs.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - Alignment checking as described above.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - `misaligned` is tied 0.
  - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`. The lane is forced to the aligned one and the access proceeds normally.
  - Illegal-`funct3` faults still apply.

## Test plan
- SW `addr`=0x10, `wdata`=0x8899AABB → `done` after 1 edge, `mem_we` high 1 cycle. Then LW 0x10 → `rdata`=0x8899AABB after 2 edges.
- Loads with word 0x8899AABB at 0x10:
  - LB 0x13 → 0xFFFFFF88
  - LBU 0x13 → 0x00000088
  - LH 0x12 → 0xFFFF8899
  - LHU 0x10 → 0x0000AABB
- SB 0x11 with `wdata`=0x12345677 → word 0x889977BB, `mem_we` high exactly 1 cycle, `done` after 2 edges. Then SH 0x12 with `wdata`=0x0000CAFE → word 0xCAFE77BB.
- LW 0x12:
  - With the macro: `misaligned`=1 and `done` after 1 edge, `mem_we` never high, `rdata` unchanged.
  - Without the macro: returns 0xCAFE77BB.
- Load with `funct3`=011 → `fault`=1 and `done` after 1 edge, no memory access. `req` pulsed while `busy` during an LB → ignored, exactly one `done`.
- SB issued, then `rst_n` low during RMW_WAIT → `mem_we` never asserted, word unchanged, all outputs 0.
